// File: rtl/mont_r2_mod.sv
// Montgomery R^2 pre-computation: R2 = 2^(2*(n_len+1)) mod n.
// Each RUN cycle doubles x and subtracts n at most once. No multiplier is used.
module mont_r2_mod #(
    parameter int unsigned WIDTH = 2048,
    parameter int unsigned LEN_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] n,
    input  logic [LEN_W-1:0] n_len,
    output logic [WIDTH-1:0] result,
    output logic             finish,
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   x_q, x_d, x2, x_red;
    logic [LEN_W+1:0] cnt_q, cnt_d, cnt_init;
    logic [LEN_W:0]   len_p1;
    logic [WIDTH-1:0] n_q, n_d, result_q, result_d;
    logic             finish_q, finish_d, err_q, err_d;
    logic             n_is_zero;

    assign n_is_zero = (n == '0);
    assign len_p1    = {1'b0, n_len} + (LEN_W+1)'(1);
    assign cnt_init  = {len_p1, 1'b0};

    // x stays below n_q, so a single conditional subtract keeps it reduced.
    assign x2    = x_q << 1;
    assign x_red = (x2 >= {1'b0, n_q}) ? x2 - {1'b0, n_q} : x2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            result_q <= '0;
            finish_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            result_q <= result_d;
            finish_q <= finish_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = n_is_zero ? StDone : StRun;
            StRun:   if (cnt_q == (LEN_W+2)'(1)) state_d = StDone;
            StDone:  if (!enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        x_d      = x_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        result_d = result_q;
        finish_d = finish_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    n_d      = n;
                    cnt_d    = cnt_init;
                    x_d      = (n == WIDTH'(1)) ? '0 : (WIDTH+1)'(1);
                    result_d = '0;
                    finish_d = n_is_zero;
                    err_d    = n_is_zero;
                end
            end
            StRun: begin
                x_d   = x_red;
                cnt_d = cnt_q - (LEN_W+2)'(1);
                if (cnt_q == (LEN_W+2)'(1)) begin
                    result_d = x_red[WIDTH-1:0];
                    finish_d = 1'b1;
                end
            end
            StDone: begin
                if (!enable) begin
                    finish_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign result = result_q;
    assign finish = finish_q;
    assign err    = err_q;

endmodule

// File: tb/tb_mont_r2_mod.sv
// Directed testbench for mont_r2_mod with hand-computed R^2 values.
module tb_mont_r2_mod;

    localparam int unsigned W = 2048;
    localparam int unsigned L = 11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] n = '0;
    logic [L-1:0] n_len = '0;
    logic [W-1:0] result;
    logic         finish;
    logic         err;

    int errors = 0;
    int checks = 0;

    mont_r2_mod #(.WIDTH(W), .LEN_W(L)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .n      (n),
        .n_len  (n_len),
        .result (result),
        .finish (finish),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Drive a start request and return just after the start edge E0.
    task automatic start_op(input logic [W-1:0] nv, input logic [L-1:0] lv, input logic keep_en);
        n = nv;
        n_len = lv;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = keep_en;
    endtask

    // Count edges after E0 until finish is seen; 0 means the bound expired.
    task automatic wait_finish(input int limit, output int lat);
        lat = 0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (finish) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got=%0b want=0", finish); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b want=0", err); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%0h want=0", result); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat;
        start_op(W'(13), L'(3), 1'b0);
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL t1_early_finish got=%0b want=0", finish); end
        wait_finish(40, lat);
        checks++; if (lat != 8) begin errors++; $display("FAIL t1_latency got=%0d want=8", lat); end
        checks++; if (result !== W'(9)) begin errors++; $display("FAIL t1_result got=%0d want=9", result); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t1_err got=%0b want=0", err); end
        @(posedge clk);
        #1;
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL t1_idle_finish got=%0b want=0", finish); end
        checks++; if (result !== W'(9)) begin errors++; $display("FAIL t1_held_result got=%0d want=9", result); end
    endtask

    task automatic test_larger();
        int lat;
        start_op(W'(197), L'(7), 1'b0);
        wait_finish(60, lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL t2_latency got=%0d want=16", lat); end
        checks++; if (result !== W'(132)) begin errors++; $display("FAIL t2_result got=%0d want=132", result); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t2_err got=%0b want=0", err); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_n_zero();
        // Previous result is 132, so a cleared result is observable.
        start_op(W'(0), L'(5), 1'b1);
        checks++; if (finish !== 1'b1) begin errors++; $display("FAIL n0_finish got=%0b want=1", finish); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL n0_err got=%0b want=1", err); end
        checks++; if (result !== '0) begin errors++; $display("FAIL n0_result got=%0d want=0", result); end
        enable = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (finish !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL n0_clear got=%0b%0b want=00", finish, err);
        end
    endtask

    task automatic test_n_one();
        int lat;
        start_op(W'(197), L'(7), 1'b0);
        wait_finish(60, lat);
        @(posedge clk);
        #1;
        start_op(W'(1), L'(0), 1'b0);
        wait_finish(20, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL n1_latency got=%0d want=2", lat); end
        checks++; if (result !== '0) begin errors++; $display("FAIL n1_result got=%0d want=0", result); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bad_len();
        int lat;
        // n_len understates n: 2^4 mod 13 = 3 after 4 edges.
        start_op(W'(13), L'(1), 1'b0);
        wait_finish(40, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL badlen_latency got=%0d want=4", lat); end
        checks++; if (result !== W'(3)) begin errors++; $display("FAIL badlen_result got=%0d want=3", result); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_max();
        int lat;
        logic [W-1:0] all_ones;
        all_ones = '1;
        start_op(all_ones, L'(W - 1), 1'b0);
        wait_finish(2 * W + 20, lat);
        checks++; if (lat != 2 * W) begin errors++; $display("FAIL max_latency got=%0d want=%0d", lat, 2 * W); end
        checks++; if (result !== W'(1)) begin errors++; $display("FAIL max_result got=%0h want=1", result); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_op(W'(13), L'(3), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (finish !== 1'b0 || result !== '0) begin
            errors++; $display("FAIL rst_mid got finish=%0b result=%0d want 0/0", finish, result);
        end
        wait_finish(12, lat);
        checks++; if (lat != 0) begin errors++; $display("FAIL rst_abort got=%0d want=0", lat); end
        start_op(W'(13), L'(3), 1'b0);
        wait_finish(40, lat);
        checks++; if (lat != 8 || result !== W'(9)) begin
            errors++; $display("FAIL rst_restart got lat=%0d result=%0d want 8/9", lat, result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        // Hold enable through RUN and DONE; change inputs mid-run.
        start_op(W'(13), L'(3), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n = W'(197);
        n_len = L'(7);
        wait_finish(40, lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL hold_latency got=%0d want=5", lat); end
        checks++; if (result !== W'(9)) begin errors++; $display("FAIL hold_result got=%0d want=9", result); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (finish !== 1'b1) begin errors++; $display("FAIL hold_done got=%0b want=1", finish); end
        enable = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (finish !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL drop_clear got=%0b%0b want=00", finish, err);
        end
        checks++; if (result !== W'(9)) begin errors++; $display("FAIL drop_result got=%0d want=9", result); end
        start_op(W'(197), L'(7), 1'b0);
        wait_finish(60, lat);
        checks++; if (lat != 16 || result !== W'(132)) begin
            errors++; $display("FAIL b2b got lat=%0d result=%0d want 16/132", lat, result);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_larger();
        test_n_zero();
        test_n_one();
        test_bad_len();
        test_max();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
